// File: rtl/key_event_queue.sv
// key_event_queue
//   Converts the debounced key level vector into discrete press events. Each
//   event is a 4-bit key code plus a repeat flag. Events are queued in a
//   show-ahead FIFO and read through a valid/ready handshake. Optional
//   hold-to-repeat, and a sticky overflow flag that is set when an event is
//   dropped.
//
// Ports
//   clk         in   system clock
//   RST         in   asynchronous reset, active-high
//   key_deb     in   debounced key levels, bit i = 1 while key i is held
//   evt_ready   in   consumer accepts the head event this cycle
//   clr_ovf     in   clears the overflow flag
//   evt_valid   out  FIFO not empty
//   evt_code    out  key index of the head event
//   evt_repeat  out  head event is an auto-repeat (0 = fresh press)
//   overflow    out  sticky: one or more events were dropped
//   fill        out  current FIFO occupancy
module key_event_queue #(
    parameter int NKEYS      = 16,
    parameter int DEPTH      = 4,
    parameter int REPEAT_DLY = 0,
    parameter int REPEAT_PER = 1,
    localparam int CODE_W    = $clog2(NKEYS),
    localparam int FILL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [NKEYS-1:0]  key_deb,
    input  logic              evt_ready,
    input  logic              clr_ovf,
    output logic              evt_valid,
    output logic [CODE_W-1:0] evt_code,
    output logic              evt_repeat,
    output logic              overflow,
    output logic [FILL_W-1:0] fill
);

    localparam int   PTR_W  = $clog2(DEPTH);
    localparam int   CNT_W  = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY + 1) : 1;
    localparam bit   RPT_EN = (REPEAT_DLY > 0);
    localparam logic [CNT_W-1:0]  DLY_C  = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0]  RLD_C  = CNT_W'(REPEAT_DLY - REPEAT_PER);
    localparam logic [FILL_W-1:0] FULL_C = FILL_W'(DEPTH);

    // state registers
    logic              init_q;
    logic [NKEYS-1:0]  key_q,  key_d;
    logic [NKEYS-1:0]  pend_q, pend_d;
    logic [CODE_W:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              ovf_q,  ovf_d;
    logic              trk_vld_q,  trk_vld_d;
    logic [CODE_W-1:0] trk_code_q, trk_code_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    // combinational helpers
    logic [NKEYS-1:0]  rise;
    logic [NKEYS-1:0]  cand;
    logic [NKEYS-1:0]  sel;
    logic              press_vld;
    logic [CODE_W-1:0] press_code;
    logic [CNT_W-1:0]  cnt_inc;
    logic              rpt_tick;
    logic              push_req;
    logic [CODE_W:0]   push_data;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic              drop;

    assign evt_valid  = (fill_q != '0);
    assign evt_code   = mem_q[rptr_q][CODE_W-1:0];
    assign evt_repeat = mem_q[rptr_q][CODE_W];
    assign overflow   = ovf_q;
    assign fill       = fill_q;

    assign cnt_inc = cnt_q + 1'b1;

    // Lowest-index pending press is served first; one press per cycle.
    always_comb begin
        rise       = init_q ? '0 : (key_deb & ~key_q);
        cand       = pend_q | rise;
        press_vld  = ~init_q & (cand != '0);
        press_code = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (cand[i]) press_code = CODE_W'(i);
        end
        sel = press_vld ? (NKEYS'(1) << press_code) : '0;
    end

    // The counter reaches REPEAT_DLY on the same edge that pushes the repeat,
    // so repeats land exactly REPEAT_DLY cycles after the press push.
    assign rpt_tick = RPT_EN & ~init_q & trk_vld_q & key_deb[trk_code_q]
                    & (cnt_inc == DLY_C);

    // A fresh press takes priority over a repeat tick in the same cycle.
    assign push_req  = press_vld | rpt_tick;
    assign push_data = press_vld ? {1'b0, press_code} : {1'b1, trk_code_q};

    assign pop     = evt_valid & evt_ready;
    assign full    = (fill_q == FULL_C);
    assign push_ok = push_req & (~full | pop);
    assign drop    = push_req & full & ~pop;

    always_comb begin
        key_d      = key_deb;
        pend_d     = init_q ? pend_q : (cand & ~sel);
        wptr_d     = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
        fill_d     = fill_q;
        ovf_d      = ovf_q;
        trk_vld_d  = trk_vld_q;
        trk_code_d = trk_code_q;
        cnt_d      = cnt_q;

        case ({push_ok, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase

        // set beats clear
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;

        if (RPT_EN && !init_q) begin
            if (press_vld) begin
                trk_vld_d  = 1'b1;
                trk_code_d = press_code;
                cnt_d      = '0;
            end else if (trk_vld_q) begin
                if (!key_deb[trk_code_q]) trk_vld_d = 1'b0;
                else if (rpt_tick)        cnt_d     = RLD_C;
                else                      cnt_d     = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            init_q     <= 1'b1;
            key_q      <= '0;
            pend_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fill_q     <= '0;
            ovf_q      <= 1'b0;
            trk_vld_q  <= 1'b0;
            trk_code_q <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            // first clock after reset only samples the keys
            init_q     <= 1'b0;
            key_q      <= key_d;
            pend_q     <= pend_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fill_q     <= fill_d;
            ovf_q      <= ovf_d;
            trk_vld_q  <= trk_vld_d;
            trk_code_q <= trk_code_d;
            cnt_q      <= cnt_d;
            if (push_ok) mem_q[wptr_q] <= push_data;
        end
    end

endmodule
